// File: rtl/csync_flywheel_generator.sv
// Composite-sync generator: synchronised TIA HSYNC/VSYNC, delayed/stretched
// horizontal pulses, serrated vsync option and a flywheel for lost HSYNC.
module csync_flywheel_generator #(
    parameter int SYNC_STAGES  = 2,
    parameter int HDELAY       = 1,
    parameter int HWIDTH       = 2,
    parameter int CNT_W        = 8,
    parameter int LINE_W       = 16,
    parameter int LINE_TIMEOUT = 228,
    parameter int INVERT       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [1:0] mode,
    input  logic       flywheel_en,
    output logic       csync,
    output logic       hsync_lost
);
    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

    localparam logic [1:0] M_SERRATED   = 2'd1;
    localparam logic [1:0] M_HSYNC_ONLY = 2'd2;
    localparam logic [1:0] M_XOR        = 2'd3;

    localparam logic [CNT_W-1:0]  DLY_LD  = CNT_W'((HDELAY > 0) ? HDELAY - 1 : 0);
    localparam logic [CNT_W-1:0]  WID_LD  = CNT_W'(HWIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_TO = LINE_W'(LINE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] hs_ff, vs_ff;
    logic                   hs_s, vs_s, hs_d;
    logic                   real_edge, synth_trig, trig;
    logic [LINE_W-1:0]      line_cnt;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   csync_q, csync_d, lost_q;
    logic                   serr, lvl_idle;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        if (g == 0) begin : g_first
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    hs_ff[0] <= 1'b1;
                    vs_ff[0] <= 1'b1;
                end else begin
                    hs_ff[0] <= hsync;
                    vs_ff[0] <= vsync;
                end
        end else begin : g_rest
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    hs_ff[g] <= 1'b1;
                    vs_ff[g] <= 1'b1;
                end else begin
                    hs_ff[g] <= hs_ff[g-1];
                    vs_ff[g] <= vs_ff[g-1];
                end
        end
    end

    assign hs_s       = hs_ff[SYNC_STAGES-1];
    assign vs_s       = vs_ff[SYNC_STAGES-1];
    assign real_edge  = hs_d & ~hs_s;
    // A real edge landing on the timeout cycle suppresses the synthetic one
    assign synth_trig = flywheel_en & ~real_edge & (line_cnt == LINE_TO);
    assign trig       = real_edge | synth_trig;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hs_d     <= 1'b1;
            line_cnt <= '0;
            lost_q   <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            csync_q  <= 1'b1;
        end else begin
            hs_d <= hs_s;
            if (trig)
                line_cnt <= '0;
            else if (line_cnt != '1)
                line_cnt <= line_cnt + 1'b1;
            if (real_edge)
                lost_q <= 1'b0;
            else if (synth_trig)
                lost_q <= 1'b1;
            state   <= state_n;
            cnt     <= cnt_n;
            csync_q <= csync_d;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (trig) begin
            if (HDELAY > 0) begin
                state_n = DELAY;
                cnt_n   = DLY_LD;
            end else begin
                state_n = PULSE;
                cnt_n   = WID_LD;
            end
        end else begin
            case (state)
                DELAY:
                    if (cnt == '0) begin
                        state_n = PULSE;
                        cnt_n   = WID_LD;
                    end else
                        cnt_n = cnt - 1'b1;
                PULSE:
                    if (cnt == '0)
                        state_n = IDLE;
                    else
                        cnt_n = cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Serration flips all three levels while vsync is active
    always_comb begin
        serr     = (mode == M_SERRATED) & ~vs_s;
        lvl_idle = (mode == M_HSYNC_ONLY) ? 1'b1 : vs_s;
        if (mode == M_XOR)
            csync_d = ~(hs_s ^ vs_s);
        else if (trig || state == DELAY)
            csync_d = ~serr;
        else if (state == PULSE)
            csync_d = serr;
        else
            csync_d = lvl_idle;
    end

    assign csync      = (INVERT != 0) ? ~csync_q : csync_q;
    assign hsync_lost = lost_q;
endmodule

// File: tb/tb_csync_flywheel_generator.sv
// Directed bench for csync_flywheel_generator; a second instance with INVERT=1
// shares all inputs so every csync check also covers the inverted output.
module tb_csync_flywheel_generator;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       flywheel_en = 1'b0;
    logic       csync, hsync_lost, csync_i, hsync_lost_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0;

    csync_flywheel_generator #(.SYNC_STAGES(1), .INVERT(0)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .mode(mode),
        .flywheel_en(flywheel_en), .csync(csync), .hsync_lost(hsync_lost));

    csync_flywheel_generator #(.SYNC_STAGES(1), .INVERT(1)) dut_inv (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .mode(mode),
        .flywheel_en(flywheel_en), .csync(csync_i), .hsync_lost(hsync_lost_i));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Step i drives hsync from hp[i], clocks once, then expects csync == ep[i]
    task automatic run_vec(input string tag, input string hp, input string ep);
        for (int i = 0; i < hp.len(); i++) begin
            hsync = (hp[i] == "1");
            tick();
            check($sformatf("%s[%0d]", tag, i), {31'd0, csync}, {31'd0, ep[i] == "1"});
            check($sformatf("%s_inv[%0d]", tag, i), {31'd0, csync_i}, {31'd0, ep[i] != "1"});
        end
        hsync = 1'b1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_csync", {31'd0, csync}, 32'd1);
        check("rst_csync_inv", {31'd0, csync_i}, 32'd0);
        check("rst_lost", {31'd0, hsync_lost}, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(4);
        check("post_rst_idle", {31'd0, csync}, 32'd1);

        run_vec("legacy", "011111", "111001");
        idle(5);

        vsync = 1'b0;
        mode  = 2'd1;
        idle(3);
        run_vec("serr_v0", "011111", "000110");
        idle(5);
        vsync = 1'b1;
        idle(3);
        run_vec("serr_v1", "011111", "111001");
        idle(5);

        mode = 2'd0;
        run_vec("retrig", "0110111111", "1110110011");
        idle(5);

        vsync = 1'b0;
        idle(3);
        check("legacy_vs_idle", {31'd0, csync}, 32'd0);
        mode = 2'd2;
        idle(2);
        run_vec("hs_only", "011111", "111001");
        idle(5);

        mode  = 2'd3;
        vsync = 1'b1;
        idle(3);
        run_vec("xor", "0011", "1001");
        idle(5);

        // Flywheel: three real lines 50 cycles apart, then HSYNC stuck high
        mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
            hsync = 1'b0;
            tick();
            e0 = cyc;
            hsync = 1'b1;
            flywheel_en = 1'b1;
            if (k < 2) idle(49);
        end
        while (cyc < e0 + 228) tick();
        check("fw_lost_before", {31'd0, hsync_lost}, 32'd0);
        tick();
        check("fw_lost_set", {31'd0, hsync_lost}, 32'd1);
        check("fw_lost_set_inv", {31'd0, hsync_lost_i}, 32'd1);
        while (cyc < e0 + 230) tick();
        check("fw1_pre", {31'd0, csync}, 32'd1);
        tick();
        check("fw1_low_a", {31'd0, csync}, 32'd0);
        tick();
        check("fw1_low_b", {31'd0, csync}, 32'd0);
        tick();
        check("fw1_end", {31'd0, csync}, 32'd1);
        while (cyc < e0 + 458) tick();
        check("fw2_pre", {31'd0, csync}, 32'd1);
        tick();
        check("fw2_low_a", {31'd0, csync}, 32'd0);
        tick();
        check("fw2_low_b", {31'd0, csync}, 32'd0);

        // Real edge landing exactly on the timeout cycle
        while (cyc < e0 + 683) tick();
        hsync = 1'b0;
        tick();
        hsync = 1'b1;
        check("coinc_lost_hold", {31'd0, hsync_lost}, 32'd1);
        tick();
        check("coinc_lost_clr", {31'd0, hsync_lost}, 32'd0);
        while (cyc < e0 + 687) tick();
        check("coinc_low_a", {31'd0, csync}, 32'd0);
        tick();
        check("coinc_low_b", {31'd0, csync}, 32'd0);

        // Line phase now follows that edge
        while (cyc < e0 + 912) tick();
        check("rephase_lost_pre", {31'd0, hsync_lost}, 32'd0);
        tick();
        check("rephase_lost", {31'd0, hsync_lost}, 32'd1);
        while (cyc < e0 + 915) tick();
        check("rephase_low", {31'd0, csync}, 32'd0);

        // Asynchronous reset in the middle of the pulse
        #2 rst = 1'b1;
        #1;
        check("midrst_csync", {31'd0, csync}, 32'd1);
        check("midrst_csync_inv", {31'd0, csync_i}, 32'd0);
        check("midrst_lost", {31'd0, hsync_lost}, 32'd0);
        flywheel_en = 1'b0;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst_after[%0d]", i), {31'd0, csync}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csync_flywheel_generator.md
Name: csync_flywheel_generator

Overview:
Parametrised composite-sync generator for the Atari video path. Derives CSYNC from the TIA's active-low HSYNC/VSYNC and adds the following:
- Input synchronisers.
- Programmable pulse delay and width.
- Selectable combine modes, including serrated vertical sync.
- Flywheel that regenerates horizontal pulses when HSYNC disappears.

It sits between the TIA sync outputs and the video DAC/encoder sync input.

Parameters:
SYNC_STAGES, 2, synchroniser flops per input (>=1); 1 gives legacy timing
HDELAY, 1, cycles of inactive (delay-level) output after trigger before the pulse (>=0)
HWIDTH, 2, active pulse width in cycles (>=1)
CNT_W, 8, width of delay/width counter; must hold max(HDELAY,HWIDTH)
LINE_W, 16, width of line-period counter
LINE_TIMEOUT, 228, cycles since last trigger before a synthetic trigger (> HDELAY+HWIDTH+1, < 2^LINE_W)
INVERT, 0, 1 = csync output active-high (final output inverted)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
hsync  input  1  TIA horizontal sync, active-low, asynchronous
vsync  input  1  TIA vertical sync, active-low, asynchronous
mode  input  2  0 LEGACY, 1 SERRATED, 2 HSYNC_ONLY, 3 XOR
flywheel_en  input  1  enables synthetic triggers on HSYNC loss
csync  output  1  composite sync (active-low unless INVERT=1), registered
hsync_lost  output  1  high while running on synthetic triggers

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Reset values:
  - All synchroniser flops and the edge-delay flop = 1.
  - state = IDLE, cnt = 0, line_cnt = 0.
  - Internal csync_q = 1, so csync = 1 (0 if INVERT).
  - hsync_lost = 0.
  - Reset mid-pulse aborts immediately.
- Synchronisers: hs_s and vs_s are the last stage of the SYNC_STAGES chains. hs_d is hs_s delayed one cycle. real_edge = hs_d & ~hs_s (falling edge, one cycle wide).
- Line counter:
  - line_cnt clears to 0 on any trigger; otherwise it increments, saturating at all-ones.
  - synth_trig = flywheel_en & ~real_edge & (line_cnt == LINE_TIMEOUT-1).
  - trig = real_edge | synth_trig.
- hsync_lost: set on synth_trig; cleared on real_edge. A real edge in the timeout cycle wins: no synthetic trigger, and hsync_lost clears.
- FSM (IDLE, DELAY, PULSE):
  - On trig in any state (retrigger restarts the sequence): if HDELAY > 0, go to DELAY with cnt = HDELAY-1; else go to PULSE with cnt = HWIDTH-1.
  - DELAY: if cnt == 0, go to PULSE with cnt = HWIDTH-1; else decrement cnt.
  - PULSE: if cnt == 0, go to IDLE; else decrement cnt.
- Output register, written every cycle:
  - In the trig cycle and in DELAY: write the delay level.
  - In PULSE (no trig): write the active level.
  - In IDLE: write the idle level.
  - Result for trig in cycle T: csync_q is low (active) in cycles T+HDELAY+2 … T+HDELAY+HWIDTH+1.
- Levels by mode (vs_s sampled in the same cycle):
  - LEGACY: idle = vs_s, delay = 1, active = 0.
  - SERRATED, vs_s = 1: same as LEGACY.
  - SERRATED, vs_s = 0: idle = 0, delay = 0, active = 1 (serration).
  - HSYNC_ONLY: idle = 1, delay = 1, active = 0; vsync ignored.
  - XOR: csync_q <= ~(hs_s ^ vs_s). FSM and flywheel still run but do not drive the output.
- Mode is sampled each cycle; a change takes effect at the next register update with no glitch beyond one-cycle granularity.
- csync = INVERT ? ~csync_q : csync_q.
- Line counter, FSM and hsync_lost operate identically in all modes.

Test Plan:
- Reset: rst=1 mid-pulse -> csync=1 and hsync_lost=0 immediately. After release with hsync=vsync=1 and mode 0 -> csync stays 1.
- Legacy timing: SYNC_STAGES=1, HDELAY=1, HWIDTH=2, mode 0, hsync falls before edge E0 -> csync=1 at E1, E2; csync=0 at E3, E4; csync=vsync level from E5.
- Serrated: mode 1, vsync held low, hsync pulses every 228 cycles -> csync low except 2-cycle high pulses at T+3..T+4 of each line. vsync high -> normal low pulses.
- Flywheel: flywheel_en=1, 3 real hsync edges then hsync stuck high -> synthetic pulse 228 cycles after last trigger and every 228 thereafter, hsync_lost=1. Next real edge -> hsync_lost=0, line re-phases to that edge.
- Retrigger: second real edge arriving during PULSE -> pulse restarts; low window = T2+3..T2+4 with an inserted 1-level cycle. Edge coinciding with timeout -> no synthetic trigger, hsync_lost unchanged or cleared.
- XOR/INVERT: mode 3, hs_s=0, vs_s=1 -> csync_q=0. INVERT=1 -> csync=1. HSYNC_ONLY with vsync low -> csync idles at 1.
